// File: rtl/sc_rr_crossbar_arbiter_nm_if.sv
// rtl/sc_rr_crossbar_arbiter_nm_if.sv - master request / slave grant bundle for the round-robin crossbar arbiter
interface sc_rr_crossbar_arbiter_nm_if #(
    parameter int N_MS  = 4,
    parameter int TMO_W = 8,
    parameter int IDX_W = $clog2(N_MS)
);
    logic [N_MS-1:0]  i_ms_req;
    logic             i_sl_ack;
    logic [TMO_W-1:0] i_tmo_lim;
    logic [N_MS-1:0]  o_ms_en;
    logic [IDX_W-1:0] o_ms_idx;
    logic             o_busy;
    logic             o_tmo;

    // Arbiter side
    modport slave (
        input  i_ms_req,
        input  i_sl_ack,
        input  i_tmo_lim,
        output o_ms_en,
        output o_ms_idx,
        output o_busy,
        output o_tmo
    );

    // Requester / crossbar side
    modport master (
        output i_ms_req,
        output i_sl_ack,
        output i_tmo_lim,
        input  o_ms_en,
        input  o_ms_idx,
        input  o_busy,
        input  o_tmo
    );
endinterface

// File: rtl/sc_rr_crossbar_arbiter_nm.sv
// rtl/sc_rr_crossbar_arbiter_nm.sv - N-master round-robin slave-port arbiter with ack/withdraw/timeout release
module sc_rr_crossbar_arbiter_nm #(
    parameter  int N_MS  = 4,
    parameter  int TMO_W = 8,
    localparam int IDX_W = $clog2(N_MS)
) (
    input  logic                           i_clk,
    input  logic                           i_resetb,
    sc_rr_crossbar_arbiter_nm_if.slave     bus
);
    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [TMO_W-1:0] cnt_q, cnt_d;
    logic [N_MS-1:0]  ms_en_q, ms_en_d;
    logic [IDX_W-1:0] ms_idx_q, ms_idx_d;
    logic             tmo_q, tmo_d;

    logic [IDX_W-1:0] win;
    logic             tmo_hit;
    logic             own_req;

    // Scan from the highest offset down so the nearest requester after ptr wins last
    always_comb begin
        int j;
        win = ptr_q;
        for (int i = N_MS; i >= 1; i--) begin
            j = int'(ptr_q) + i;
            if (j >= N_MS) begin
                j = j - N_MS;
            end
            if (bus.i_ms_req[j]) begin
                win = IDX_W'(j);
            end
        end
    end

    // A saturated counter still times out so a late-lowered limit cannot hold the slave forever
    assign tmo_hit = (bus.i_tmo_lim != '0) &&
                     ((cnt_q == (bus.i_tmo_lim - TMO_W'(1))) || (&cnt_q));
    assign own_req = bus.i_ms_req[ms_idx_q];

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        ms_en_d  = ms_en_q;
        ms_idx_d = ms_idx_q;
        tmo_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (|bus.i_ms_req) begin
                    state_d  = BUSY;
                    ms_en_d  = N_MS'(1) << win;
                    ms_idx_d = win;
                    ptr_d    = win;
                    cnt_d    = '0;
                end
            end
            BUSY: begin
                if (bus.i_sl_ack || !own_req || tmo_hit) begin
                    state_d  = IDLE;
                    ms_en_d  = '0;
                    ms_idx_d = '0;
                    tmo_d    = !bus.i_sl_ack && own_req;
                end else if (!(&cnt_q)) begin
                    cnt_d = cnt_q + TMO_W'(1);
                end
            end
            default: begin
                state_d  = IDLE;
                ms_en_d  = '0;
                ms_idx_d = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_resetb) begin
        if (!i_resetb) begin
            state_q  <= IDLE;
            ptr_q    <= IDX_W'(N_MS - 1);
            cnt_q    <= '0;
            ms_en_q  <= '0;
            ms_idx_q <= '0;
            tmo_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            ms_en_q  <= ms_en_d;
            ms_idx_q <= ms_idx_d;
            tmo_q    <= tmo_d;
        end
    end

    assign bus.o_ms_en  = ms_en_q;
    assign bus.o_ms_idx = ms_idx_q;
    assign bus.o_busy   = (state_q == BUSY);
    assign bus.o_tmo    = tmo_q;
endmodule

// File: tb/tb_sc_rr_crossbar_arbiter_nm.sv
// tb/tb_sc_rr_crossbar_arbiter_nm.sv - directed bench for the round-robin crossbar arbiter
module tb_sc_rr_crossbar_arbiter_nm;
    logic clk;
    logic rst_n;
    int   n_assert;
    int   n_fail;
    int   tmo_seen;
    int   busy_lost;

    sc_rr_crossbar_arbiter_nm_if #(.N_MS(4), .TMO_W(8)) bus ();

    sc_rr_crossbar_arbiter_nm #(.N_MS(4), .TMO_W(8)) dut (
        .i_clk    (clk),
        .i_resetb (rst_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] en, input logic [1:0] idx,
                           input logic busy, input logic tmo);
        chk({tag, ".en"},   32'(bus.o_ms_en),  32'(en));
        chk({tag, ".idx"},  32'(bus.o_ms_idx), 32'(idx));
        chk({tag, ".busy"}, 32'(bus.o_busy),   32'(busy));
        chk({tag, ".tmo"},  32'(bus.o_tmo),    32'(tmo));
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst_n = 1'b0;
        bus.i_ms_req  = 4'b0000;
        bus.i_sl_ack  = 1'b0;
        bus.i_tmo_lim = 8'd0;
        step();
        step();
        chk_out("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        step();
        chk_out("idle_noreq", 4'b0000, 2'd0, 1'b0, 1'b0);

        // all four requesting: 0,1,2,3,0 with an idle cycle after each ack
        bus.i_ms_req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            step();
            chk_out($sformatf("rr_grant%0d", k), 4'(1 << (k % 4)), 2'(k % 4), 1'b1, 1'b0);
            bus.i_sl_ack = 1'b1;
            step();
            bus.i_sl_ack = 1'b0;
            chk_out($sformatf("rr_gap%0d", k), 4'b0000, 2'd0, 1'b0, 1'b0);
        end

        // single requester 2
        bus.i_ms_req = 4'b0100;
        step();
        chk_out("single2", 4'b0100, 2'd2, 1'b1, 1'b0);
        bus.i_sl_ack = 1'b1;
        step();
        bus.i_sl_ack = 1'b0;
        bus.i_ms_req = 4'b0000;
        chk_out("single2_ack", 4'b0000, 2'd0, 1'b0, 1'b0);
        step();
        chk_out("ack_ignored_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

        // pointer to 0, then grant master 1 and withdraw its request
        bus.i_ms_req = 4'b0001;
        step();
        chk_out("pre_m0", 4'b0001, 2'd0, 1'b1, 1'b0);
        bus.i_sl_ack = 1'b1;
        step();
        bus.i_sl_ack = 1'b0;
        bus.i_ms_req = 4'b0011;
        step();
        chk_out("m1_grant", 4'b0010, 2'd1, 1'b1, 1'b0);
        bus.i_ms_req = 4'b0001;
        step();
        chk_out("m1_withdraw", 4'b0000, 2'd0, 1'b0, 1'b0);
        step();
        chk_out("m0_after_withdraw", 4'b0001, 2'd0, 1'b1, 1'b0);
        bus.i_ms_req = 4'b0000;
        step();
        chk_out("m0_withdraw", 4'b0000, 2'd0, 1'b0, 1'b0);

        // timeout with limit 5 on master 3
        bus.i_tmo_lim = 8'd5;
        bus.i_ms_req  = 4'b1000;
        for (int c = 0; c < 5; c++) begin
            step();
            chk_out($sformatf("tmo5_busy%0d", c), 4'b1000, 2'd3, 1'b1, 1'b0);
        end
        step();
        chk_out("tmo5_fire", 4'b0000, 2'd0, 1'b0, 1'b1);
        bus.i_ms_req = 4'b0000;
        step();
        chk_out("tmo5_after", 4'b0000, 2'd0, 1'b0, 1'b0);

        // timeout disabled: grant held for 300 cycles
        bus.i_tmo_lim = 8'd0;
        bus.i_ms_req  = 4'b1000;
        tmo_seen  = 0;
        busy_lost = 0;
        step();
        chk_out("notmo_grant", 4'b1000, 2'd3, 1'b1, 1'b0);
        for (int c = 0; c < 300; c++) begin
            step();
            if (bus.o_tmo !== 1'b0) tmo_seen++;
            if (bus.o_busy !== 1'b1) busy_lost++;
        end
        chk("notmo_tmo_count", 32'(tmo_seen), 32'd0);
        chk("notmo_busy_lost", 32'(busy_lost), 32'd0);
        chk_out("notmo_held", 4'b1000, 2'd3, 1'b1, 1'b0);
        bus.i_sl_ack = 1'b1;
        step();
        bus.i_sl_ack = 1'b0;
        bus.i_ms_req = 4'b0000;
        chk_out("notmo_ack", 4'b0000, 2'd0, 1'b0, 1'b0);

        // ack on the 5th busy cycle beats the timeout
        bus.i_tmo_lim = 8'd5;
        bus.i_ms_req  = 4'b0010;
        step();
        chk_out("ackvs_grant", 4'b0010, 2'd1, 1'b1, 1'b0);
        for (int c = 0; c < 4; c++) begin
            step();
        end
        chk_out("ackvs_cycle5", 4'b0010, 2'd1, 1'b1, 1'b0);
        bus.i_sl_ack = 1'b1;
        step();
        bus.i_sl_ack = 1'b0;
        bus.i_ms_req = 4'b0000;
        chk_out("ackvs_end", 4'b0000, 2'd0, 1'b0, 1'b0);
        step();
        chk_out("ackvs_quiet", 4'b0000, 2'd0, 1'b0, 1'b0);

        // asynchronous reset mid-transaction
        bus.i_tmo_lim = 8'd0;
        bus.i_ms_req  = 4'b0100;
        step();
        chk_out("rst_pre", 4'b0100, 2'd2, 1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        chk_out("rst_async", 4'b0000, 2'd0, 1'b0, 1'b0);
        bus.i_ms_req = 4'b0101;
        step();
        chk_out("rst_hold", 4'b0000, 2'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        step();
        chk_out("rst_m0", 4'b0001, 2'd0, 1'b1, 1'b0);
        bus.i_sl_ack = 1'b1;
        step();
        bus.i_sl_ack = 1'b0;
        chk_out("rst_m0_ack", 4'b0000, 2'd0, 1'b0, 1'b0);
        step();
        chk_out("rst_m2_next", 4'b0100, 2'd2, 1'b1, 1'b0);
        bus.i_ms_req = 4'b0000;
        step();
        chk_out("final_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
